memory_access_sequencer: RTL and testbench
==========================================

// Module: memory_access_sequencer
// PURPOSE
//   Initiator side of the 16-bit word memory interface (read/write/address/data_in/data_out).
//   Accepts commands from the adding-machine datapath over a valid/ready handshake and issues
//   memory cycles: single READ, single WRITE, and SUM (stream-add a block of words, write the
//   total back). Returns one response per command. Sits between control logic and the memory.
// PARAMETERS
//   ADDR_WIDTH  8   memory address width; word count width is ADDR_WIDTH+1
//   DATA_WIDTH  16  memory word / accumulator width
// PORTS
//   clock          in   1             rising-edge clock, single clock domain
//   reset_n        in   1             asynchronous, active-low reset
//   cmd_valid      in   1             command present
//   cmd_ready      out  1             sequencer can accept a command (high only in IDLE)
//   cmd_op         in   2             00 READ, 01 WRITE, 10 SUM, 11 reserved
//   cmd_address    in   ADDR_WIDTH    READ/WRITE address; SUM source start address
//   cmd_dest       in   ADDR_WIDTH    SUM destination address
//   cmd_count      in   ADDR_WIDTH+1  SUM word count, 0..2**ADDR_WIDTH
//   cmd_data       in   DATA_WIDTH    WRITE data
//   resp_valid     out  1             response present, held until resp_ready
//   resp_ready     in   1             consumer accepts response
//   resp_data      out  DATA_WIDTH    READ word / WRITE echo / SUM total
//   resp_overflow  out  1             SUM: at least one carry out of DATA_WIDTH
//   resp_error     out  1             reserved opcode
//   mem_read       out  1             to memory read
//   mem_write      out  1             to memory write
//   mem_address    out  ADDR_WIDTH    to memory address
//   mem_wdata      out  DATA_WIDTH    to memory data_in
//   mem_rdata      in   DATA_WIDTH    from memory data_out (registered, valid the cycle after mem_read)
// BEHAVIOUR
//   - All outputs registered. reset_n low: state IDLE, every output 0, cmd_ready goes 1 after release.
//   - Reset mid-command aborts at once: mem_read/mem_write drop to 0, accumulator and response cleared,
//     no response issued for the aborted command.
//   - Command accepted on the edge where cmd_valid && cmd_ready (E0); all cmd_* fields latched then.
//   - mem_read and mem_write never high together; mem_* are 0 outside issue cycles.
//   - FSM: IDLE, READ_ISSUE, READ_CAPTURE, WRITE_ISSUE, SUM_STREAM, SUM_DRAIN, SUM_WRITE, RESPOND.
//   - READ: cycle 1 READ_ISSUE (mem_read=1, mem_address); cycle 2 READ_CAPTURE samples mem_rdata;
//     cycle 3 RESPOND, resp_data = word.
//   - WRITE: cycle 1 WRITE_ISSUE (mem_write=1, mem_wdata=cmd_data); cycle 2 RESPOND, resp_data=cmd_data.
//   - SUM, count N>=1: cycles 1..N SUM_STREAM issues mem_read at start, start+1, ... (one per cycle);
//     the accumulator adds mem_rdata in cycles 2..N+1 (cycle N+1 = SUM_DRAIN); cycle N+2 SUM_WRITE
//     drives mem_write=1, mem_address=cmd_dest, mem_wdata=sum; cycle N+3 RESPOND.
//   - SUM, N=0: cycle 1 SUM_WRITE writes 0x0000 to dest; cycle 2 RESPOND, data 0, overflow 0.
//   - cmd_count > 2**ADDR_WIDTH saturates to 2**ADDR_WIDTH.
//   - Address increments modulo 2**ADDR_WIDTH (0xFF -> 0x00).
//   - Sum is modulo 2**DATA_WIDTH; resp_overflow is sticky for the command and is set on any carry.
//   - dest may lie inside the source range; the write happens after all reads, so sources are unaffected.
//   - Reserved op: no memory access; cycle 1 RESPOND with resp_error=1, resp_data=0.
//   - RESPOND: resp_valid=1 with stable fields until the resp_ready edge. That edge returns to IDLE and
//     clears resp_*. A new command is accepted no earlier than the following cycle.
//   - resp_error is 0 for non-reserved ops; resp_overflow is 0 for non-SUM ops.
// TESTING
//   1. Reset: reset_n low mid-SUM stream -> mem_read=0 in same cycle, resp_valid=0, cmd_ready=1 after release.
//   2. WRITE addr 0x10 data 0xBEEF, then READ 0x10 -> mem_write pulse 1 cycle; READ resp_data=0xBEEF,
//      resp_valid 3 cycles after accept.
//   3. SUM start 0x20 count 4 over {1,2,3,4}, dest 0x30 -> reads 0x20..0x23 on consecutive cycles,
//      write 0x000A to 0x30 at cycle 6, resp_data=0x000A, overflow 0.
//   4. SUM start 0xFE count 3 over {0xFFFF,0x0002,0x0001}, dest 0x00 -> reads 0xFE,0xFF,0x00;
//      resp_data=0x0002, overflow 1; the later read of 0x00 returns 0x0002.
//   5. SUM count 0 -> single write of 0x0000 to dest, resp_valid cycle 2; reserved op 11 -> no mem
//      strobes, resp_error=1.
//   6. Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, cmd_ready=0, no mem activity.

Source files
------------

// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer
//   Initiator for a word-wide memory with registered read data. Takes one
//   command at a time (READ, WRITE, SUM over a block, reserved -> error),
//   drives the memory strobes, and returns exactly one response per command.
//
//   Handshakes (both command and response side): a transfer happens on the
//   rising clock edge where valid && ready are both high. The producer keeps
//   valid and its payload stable until that edge. cmd_ready is only offered
//   in IDLE. resp_valid stays high with frozen fields until resp_ready.
module memory_access_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [ADDR_WIDTH-1:0] cmd_dest,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_overflow,
    output logic                  resp_error,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        READ_ISSUE   = 3'd1,
        READ_CAPTURE = 3'd2,
        WRITE_ISSUE  = 3'd3,
        SUM_STREAM   = 3'd4,
        SUM_DRAIN    = 3'd5,
        SUM_WRITE    = 3'd6,
        RESPOND      = 3'd7
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SUM   = 2'b10;

    // Largest legal block: the whole address space.
    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] dest_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH:0]   remaining;   // SUM reads still to issue after the current one
    logic [DATA_WIDTH-1:0] acc;
    logic                  ovf;
    logic                  pend;        // mem_rdata carries a word requested last cycle

    logic [ADDR_WIDTH:0]   count_sat;
    logic [DATA_WIDTH:0]   sum_wide;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  ovf_next;

    // Oversized block requests are clamped to the full address space.
    assign count_sat = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;

    // Accumulator update: only fold in mem_rdata when a read was issued the
    // cycle before; the carry out of the top bit makes overflow sticky.
    assign sum_wide = {1'b0, acc} + {1'b0, mem_rdata};
    assign acc_next = pend ? sum_wide[DATA_WIDTH-1:0] : acc;
    assign ovf_next = ovf | (pend & sum_wide[DATA_WIDTH]);

    assign fsm_state = state;

    // Sequencer FSM: every output is a register updated here. Memory strobes
    // default to 0 each cycle and are raised only for the issue cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_overflow <= 1'b0;
            resp_error    <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_wdata     <= '0;
            dest_q        <= '0;
            data_q        <= '0;
            remaining     <= '0;
            acc           <= '0;
            ovf           <= 1'b0;
            pend          <= 1'b0;
        end else begin
            pend        <= mem_read;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        dest_q    <= cmd_dest;
                        data_q    <= cmd_data;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        case (cmd_op)
                            OP_READ: begin
                                mem_read    <= 1'b1;
                                mem_address <= cmd_address;
                                state       <= READ_ISSUE;
                            end
                            OP_WRITE: begin
                                mem_write   <= 1'b1;
                                mem_address <= cmd_address;
                                mem_wdata   <= cmd_data;
                                state       <= WRITE_ISSUE;
                            end
                            OP_SUM: begin
                                if (count_sat == '0) begin
                                    // Empty block: write a zero total straight away.
                                    mem_write   <= 1'b1;
                                    mem_address <= cmd_dest;
                                    state       <= SUM_WRITE;
                                end else begin
                                    mem_read    <= 1'b1;
                                    mem_address <= cmd_address;
                                    remaining   <= count_sat - COUNT_ONE;
                                    state       <= SUM_STREAM;
                                end
                            end
                            default: begin
                                // Reserved opcode: no memory traffic, error response.
                                resp_valid <= 1'b1;
                                resp_error <= 1'b1;
                                resp_data  <= '0;
                                state      <= RESPOND;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                READ_ISSUE: begin
                    state <= READ_CAPTURE;
                end

                READ_CAPTURE: begin
                    resp_valid <= 1'b1;
                    resp_data  <= mem_rdata;
                    state      <= RESPOND;
                end

                WRITE_ISSUE: begin
                    resp_valid <= 1'b1;
                    resp_data  <= data_q;
                    state      <= RESPOND;
                end

                SUM_STREAM: begin
                    acc <= acc_next;
                    ovf <= ovf_next;
                    if (remaining == '0) begin
                        state <= SUM_DRAIN;
                    end else begin
                        // Address wraps naturally at the top of the space.
                        mem_read    <= 1'b1;
                        mem_address <= mem_address + ADDR_ONE;
                        remaining   <= remaining - COUNT_ONE;
                    end
                end

                SUM_DRAIN: begin
                    // Last word arrives now; the total goes straight to memory.
                    acc         <= acc_next;
                    ovf         <= ovf_next;
                    mem_write   <= 1'b1;
                    mem_address <= dest_q;
                    mem_wdata   <= acc_next;
                    state       <= SUM_WRITE;
                end

                SUM_WRITE: begin
                    resp_valid    <= 1'b1;
                    resp_data     <= acc;
                    resp_overflow <= ovf;
                    state         <= RESPOND;
                end

                RESPOND: begin
                    if (resp_ready) begin
                        resp_valid    <= 1'b0;
                        resp_data     <= '0;
                        resp_overflow <= 1'b0;
                        resp_error    <= 1'b0;
                        acc           <= '0;
                        ovf           <= 1'b0;
                        cmd_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: a behavioural word memory, command
// drivers, a response scoreboard (expected {error, overflow, data} and
// latency queues) and per-scenario test tasks.
module tb_memory_access_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_address = '0;
    logic [AW-1:0] cmd_dest = '0;
    logic [AW:0]   cmd_count = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          resp_overflow;
    logic          resp_error;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    fsm_state;

    memory_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_dest(cmd_dest), .cmd_count(cmd_count),
        .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_overflow(resp_overflow), .resp_error(resp_error),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:255];
    always @(posedge clock) begin
        if (mem_read)  mem_rdata <= mem[mem_address];
        if (mem_write) mem[mem_address] <= mem_wdata;
    end

    // ---------------- access log / strobe monitor ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } access_t;
    access_t log_q[$];
    int both_err = 0;
    int idle_err = 0;

    always @(negedge clock) begin
        if (mem_read === 1'b1)  log_q.push_back('{1'b0, mem_address, mem_wdata, cyc});
        if (mem_write === 1'b1) log_q.push_back('{1'b1, mem_address, mem_wdata, cyc});
        if (mem_read === 1'b1 && mem_write === 1'b1) both_err++;
        if (mem_read !== 1'b1 && mem_write !== 1'b1 && (mem_address !== '0 || mem_wdata !== '0))
            idle_err++;
    end

    // ---------------- scoreboard ----------------
    logic [DW+1:0] exp_q[$];   // {error, overflow, data}
    int            lat_q[$];   // response cycle index after accept
    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;

    // ---------------- drivers ----------------
    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [AW-1:0] dest, input logic [AW:0] count,
                          input logic [DW-1:0] data);
        int n = 0;
        @(negedge clock);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout got %b exp 1", cmd_ready);
        end
        log_q.delete();
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_address = addr;
        cmd_dest    = dest;
        cmd_count   = count;
        cmd_data    = data;
        @(posedge clock);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(output logic [DW+1:0] got, output int lat);
        int n = 0;
        @(negedge clock);
        while (resp_valid !== 1'b1 && n < 600) begin
            @(negedge clock);
            n++;
        end
        if (resp_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout got resp_valid=%b exp 1", resp_valid);
            got = 'x;
            lat = -1;
        end else begin
            got = {resp_error, resp_overflow, resp_data};
            lat = cyc - acc_cyc + 1;
            resp_ready = 1'b1;
            @(posedge clock);
            #1;
            resp_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({cmd_ready, resp_valid, resp_data, resp_overflow, resp_error,
             mem_read, mem_write, mem_address, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b rv=%b rd=%b wr=%b", cmd_ready, resp_valid, mem_read, mem_write);
        end
        checks++;
        if (fsm_state !== 3'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got %b exp 1", cmd_ready); end

        // Abort a long SUM while it is streaming reads.
        do_cmd(2'b10, 8'h50, 8'h60, 9'd20, '0);
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (mem_read !== 1'b1) begin failures++; $display("FAIL sum_streaming got mem_read=%b exp 1", mem_read); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || resp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got rd=%b rv=%b rdy=%b exp 0 0 0", mem_read, resp_valid, cmd_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_abort got %b exp 1", cmd_ready); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad); end
    endtask

    task automatic test_write_read();
        logic [DW+1:0] got, e;
        int lat, el;
        exp_q.push_back({2'b00, 16'hBEEF});
        lat_q.push_back(2);
        do_cmd(2'b01, 8'h10, 8'h00, 9'd0, 16'hBEEF);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL write_resp got %h exp %h", got, e); end
        checks++;
        if (lat != el) begin failures++; $display("FAIL write_latency got %0d exp %0d", lat, el); end
        checks++;
        if (log_q.size() != 1) begin
            failures++; $display("FAIL write_strobes got %0d accesses exp 1", log_q.size());
        end else if (!log_q[0].wr || log_q[0].a !== 8'h10 || log_q[0].d !== 16'hBEEF ||
                     log_q[0].c - acc_cyc + 1 != 1) begin
            failures++;
            $display("FAIL write_access got wr=%b a=%h d=%h k=%0d exp 1 10 beef 1",
                     log_q[0].wr, log_q[0].a, log_q[0].d, log_q[0].c - acc_cyc + 1);
        end

        exp_q.push_back({2'b00, 16'hBEEF});
        lat_q.push_back(3);
        do_cmd(2'b00, 8'h10, 8'h00, 9'd0, 16'h0000);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL read_resp got %h exp %h", got, e); end
        checks++;
        if (lat != el) begin failures++; $display("FAIL read_latency got %0d exp %0d", lat, el); end
        checks++;
        if (log_q.size() != 1 || log_q[0].wr || log_q[0].a !== 8'h10 || log_q[0].c - acc_cyc + 1 != 1) begin
            failures++; $display("FAIL read_access got %0d accesses exp 1 read of 10 in cycle 1", log_q.size());
        end
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL resp_release got rv=%b rdy=%b exp 0 1", resp_valid, cmd_ready);
        end
    endtask

    task automatic test_sum();
        logic [DW+1:0] got, e;
        int lat, el, bad;
        for (int i = 0; i < 4; i++) mem[8'h20 + i] = 16'(i + 1);
        mem[8'h30] = 16'hDEAD;
        exp_q.push_back({2'b00, 16'h000A});
        lat_q.push_back(7);
        do_cmd(2'b10, 8'h20, 8'h30, 9'd4, '0);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL sum_resp got %h exp %h", got, e); end
        checks++;
        if (lat != el) begin failures++; $display("FAIL sum_latency got %0d exp %0d", lat, el); end
        bad = 0;
        if (log_q.size() != 5) bad = 1;
        else begin
            for (int i = 0; i < 4; i++)
                if (log_q[i].wr || log_q[i].a !== 8'(8'h20 + i) || log_q[i].c - acc_cyc + 1 != i + 1) bad = 1;
            if (!log_q[4].wr || log_q[4].a !== 8'h30 || log_q[4].d !== 16'h000A || log_q[4].c - acc_cyc + 1 != 6) bad = 1;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL sum_sequence got %0d accesses exp 4 reads then write at cycle 6", log_q.size()); end
        checks++;
        if (mem[8'h30] !== 16'h000A) begin failures++; $display("FAIL sum_dest got %h exp 000a", mem[8'h30]); end
    endtask

    task automatic test_sum_wrap();
        logic [DW+1:0] got, e;
        int lat, el, bad;
        logic [AW-1:0] exp_a [0:2];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        mem[8'hFE] = 16'hFFFF; mem[8'hFF] = 16'h0002; mem[8'h00] = 16'h0001;
        exp_q.push_back({2'b01, 16'h0002});
        lat_q.push_back(6);
        do_cmd(2'b10, 8'hFE, 8'h00, 9'd3, '0);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL wrap_resp got %h exp %h", got, e); end
        checks++;
        if (lat != el) begin failures++; $display("FAIL wrap_latency got %0d exp %0d", lat, el); end
        bad = 0;
        if (log_q.size() != 4) bad = 1;
        else begin
            for (int i = 0; i < 3; i++)
                if (log_q[i].wr || log_q[i].a !== exp_a[i] || log_q[i].c - acc_cyc + 1 != i + 1) bad = 1;
            if (!log_q[3].wr || log_q[3].a !== 8'h00 || log_q[3].d !== 16'h0002 || log_q[3].c - acc_cyc + 1 != 5) bad = 1;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wrap_sequence got %0d accesses exp reads fe ff 00 then write", log_q.size()); end

        exp_q.push_back({2'b00, 16'h0002});
        lat_q.push_back(3);
        do_cmd(2'b00, 8'h00, 8'h00, 9'd0, '0);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e || lat != el) begin failures++; $display("FAIL wrap_readback got %h lat %0d exp %h lat %0d", got, lat, e, el); end
    endtask

    task automatic test_zero_reserved();
        logic [DW+1:0] got, e;
        int lat, el;
        mem[8'h40] = 16'h1234;
        exp_q.push_back({2'b00, 16'h0000});
        lat_q.push_back(2);
        do_cmd(2'b10, 8'h33, 8'h40, 9'd0, 16'hFFFF);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e || lat != el) begin failures++; $display("FAIL zero_resp got %h lat %0d exp %h lat %0d", got, lat, e, el); end
        checks++;
        if (log_q.size() != 1 || !log_q[0].wr || log_q[0].a !== 8'h40 || log_q[0].d !== 16'h0000 ||
            log_q[0].c - acc_cyc + 1 != 1 || mem[8'h40] !== 16'h0000) begin
            failures++; $display("FAIL zero_write got %0d accesses mem40=%h exp one write of 0000", log_q.size(), mem[8'h40]);
        end

        exp_q.push_back({2'b10, 16'h0000});
        lat_q.push_back(1);
        do_cmd(2'b11, 8'h12, 8'h34, 9'd5, 16'h5555);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e || lat != el) begin failures++; $display("FAIL reserved_resp got %h lat %0d exp %h lat %0d", got, lat, e, el); end
        checks++;
        if (log_q.size() != 0) begin failures++; $display("FAIL reserved_strobes got %0d accesses exp 0", log_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [DW+1:0] got, e;
        int n;
        exp_q.push_back({2'b00, 16'h1357});
        do_cmd(2'b01, 8'h77, 8'h00, 9'd0, 16'h1357);
        n = 0;
        @(negedge clock);
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            got = {resp_error, resp_overflow, resp_data};
            checks++;
            if (resp_valid !== 1'b1 || got !== e || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got rv=%b resp=%h rdy=%b exp 1 %h 0", i, resp_valid, got, cmd_ready, e);
            end
            @(negedge clock);
        end
        checks++;
        if (log_q.size() != 1) begin failures++; $display("FAIL hold_mem_activity got %0d accesses exp 1", log_q.size()); end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL hold_release got %b exp 0", resp_valid); end
    endtask

    task automatic test_sum_random(input int start, input int count, input int dest, input string tag);
        logic [DW+1:0] got, e;
        logic [DW:0]   s;
        bit            ov;
        int lat, el, n_eff, reads, bad;
        n_eff = (count > 256) ? 256 : count;
        for (int i = 0; i < n_eff; i++) mem[8'(start + i)] = 16'($urandom_range(0, 65535));
        s = '0; ov = 1'b0;
        for (int i = 0; i < n_eff; i++) begin
            s = {1'b0, s[DW-1:0]} + {1'b0, mem[8'(start + i)]};
            if (s[DW]) ov = 1'b1;
        end
        exp_q.push_back({1'b0, ov, s[DW-1:0]});
        lat_q.push_back(n_eff + 3);
        do_cmd(2'b10, 8'(start), 8'(dest), 9'(count), '0);
        collect(got, lat);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (got !== e || lat != el) begin
            failures++; $display("FAIL %s_resp got %h lat %0d exp %h lat %0d", tag, got, lat, e, el);
        end
        reads = 0; bad = 0;
        foreach (log_q[i]) begin
            if (!log_q[i].wr) begin
                if (log_q[i].a !== 8'(start + reads) || log_q[i].c - acc_cyc + 1 != reads + 1) bad = 1;
                reads++;
            end else if (log_q[i].a !== 8'(dest) || log_q[i].d !== s[DW-1:0] ||
                         log_q[i].c - acc_cyc + 1 != n_eff + 2) bad = 1;
        end
        checks++;
        if (bad != 0 || reads != n_eff || log_q.size() != n_eff + 1) begin
            failures++; $display("FAIL %s_sequence got %0d reads %0d accesses exp %0d reads", tag, reads, log_q.size(), n_eff);
        end
    endtask

    task automatic test_strobes();
        checks++;
        if (both_err != 0) begin failures++; $display("FAIL read_write_overlap got %0d exp 0", both_err); end
        checks++;
        if (idle_err != 0) begin failures++; $display("FAIL idle_bus_nonzero got %0d exp 0", idle_err); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_sum();
        test_sum_wrap();
        test_zero_reserved();
        test_backpressure();
        test_sum_random(8'h80, 9'h1FF, 8'h85, "saturate");
        for (int t = 0; t < 4; t++)
            test_sum_random($urandom_range(0, 255), $urandom_range(1, 20), $urandom_range(0, 255), "random");
        test_sum_random(8'h10, 1, 8'h10, "single");
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
